// File: rtl/axi_ddr_responder.sv
// axi_ddr_responder: AXI4 AW/W/AR/R responder over a single-port RAM (DDR stand-in / small frame store).
// Build option: define AXI_RESP_WSTRB_EN to byte-mask RAM writes by WSTRB; otherwise every beat writes the full word.
module axi_ddr_responder #(
   parameter int S_AXI_ID_WIDTH   = 4,
   parameter int S_AXI_ADDR_WIDTH = 28,
   parameter int S_AXI_DATA_WIDTH = 256,
   parameter int MEM_DEPTH_BITS   = 12,
   parameter int RD_PRIORITY      = 0
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                    S_AXI_AWLEN,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_WID,
   input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                          S_AXI_WLAST,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                    S_AXI_ARLEN,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
   output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic                          S_AXI_RLAST,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [15:0]                   wr_burst_cnt,
   output logic [15:0]                   rd_burst_cnt,
   output logic                          proto_err
);
   // state  | meaning
   // IDLE   | address channels open, AW/AR arbitration
   // WBURST | accepting W beats into the RAM
   // RBURST | streaming R beats out of the RAM
   typedef enum logic [1:0] {IDLE = 2'd0, WBURST = 2'd1, RBURST = 2'd2} state_t;

   localparam int BYTES = S_AXI_DATA_WIDTH / 8;
   localparam int OFFS  = $clog2(BYTES);
   localparam int DEPTH = 1 << MEM_DEPTH_BITS;

   state_t state, state_nxt;
   logic [S_AXI_DATA_WIDTH-1:0] mem [DEPTH];
   logic [MEM_DEPTH_BITS-1:0]   beat_addr;
   logic [7:0]                  len;
   logic [8:0]                  cnt;
   logic [S_AXI_ID_WIDTH-1:0]   aw_id, r_id;
   logic [S_AXI_DATA_WIDTH-1:0] r_data;
   logic                        r_valid, r_last, run, rd_turn, err;
   logic [15:0]                 wr_cnt, rd_cnt;
   logic                        aw_ready, ar_ready, w_ready;
   logic                        contend, aw_hs, ar_hs, w_hs, r_hs, rd_issue, final_beat;

   assign contend    = S_AXI_AWVALID && S_AXI_ARVALID;
   assign aw_hs      = S_AXI_AWVALID && aw_ready;
   assign ar_hs      = S_AXI_ARVALID && ar_ready;
   assign w_hs       = S_AXI_WVALID && w_ready;
   assign r_hs       = r_valid && S_AXI_RREADY;
   assign final_beat = (cnt[7:0] == len);
   assign rd_issue   = (state == RBURST) && (!r_valid || S_AXI_RREADY) && (cnt <= {1'b0, len});

   always_comb begin
      state_nxt = state;
      aw_ready  = 1'b0;
      ar_ready  = 1'b0;
      w_ready   = 1'b0;
      case (state)
         IDLE: begin
            // run keeps the READYs low while reset is asserted
            if (run) begin
               aw_ready = !(contend && rd_turn);
               ar_ready = !(contend && !rd_turn);
            end
            if (S_AXI_AWVALID && aw_ready)
               state_nxt = WBURST;
            else if (S_AXI_ARVALID && ar_ready)
               state_nxt = RBURST;
         end
         WBURST: begin
            w_ready = 1'b1;
            if (S_AXI_WVALID && final_beat)
               state_nxt = IDLE;
         end
         RBURST: begin
            if (r_hs && r_last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state     <= IDLE;
         run       <= 1'b0;
         rd_turn   <= (RD_PRIORITY != 0);
         beat_addr <= '0;
         len       <= '0;
         cnt       <= '0;
         aw_id     <= '0;
         r_id      <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         err       <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
         // the loser of a contention wins the next one
         if (state == IDLE && run && contend)
            rd_turn <= !rd_turn;
         if (aw_hs) begin
            beat_addr <= S_AXI_AWADDR[OFFS +: MEM_DEPTH_BITS];
            len       <= S_AXI_AWLEN;
            aw_id     <= S_AXI_AWID;
            cnt       <= '0;
         end else if (ar_hs) begin
            beat_addr <= S_AXI_ARADDR[OFFS +: MEM_DEPTH_BITS];
            len       <= S_AXI_ARLEN;
            r_id      <= S_AXI_ARID;
            cnt       <= '0;
         end
         if (w_hs) begin
            beat_addr <= beat_addr + 1'b1;
            cnt       <= cnt + 9'd1;
            if ((S_AXI_WLAST != final_beat) || (S_AXI_WID != aw_id))
               err <= 1'b1;
            if (final_beat)
               wr_cnt <= wr_cnt + 16'd1;
         end
         if (rd_issue) begin
            beat_addr <= beat_addr + 1'b1;
            cnt       <= cnt + 9'd1;
            r_data    <= mem[beat_addr];
            r_valid   <= 1'b1;
            r_last    <= final_beat;
         end else if (r_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
         if (r_hs && r_last)
            rd_cnt <= rd_cnt + 16'd1;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (w_hs) begin
`ifdef AXI_RESP_WSTRB_EN
         for (int b = 0; b < BYTES; b++)
            if (S_AXI_WSTRB[b])
               mem[beat_addr][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
`else
         mem[beat_addr] <= S_AXI_WDATA;
`endif
      end
   end

`ifndef AXI_RESP_WSTRB_EN
   logic unused_strb;
   assign unused_strb = ^S_AXI_WSTRB;
`endif
   logic unused_addr;
   assign unused_addr = ^{S_AXI_AWADDR[OFFS-1:0], S_AXI_AWADDR[S_AXI_ADDR_WIDTH-1:OFFS+MEM_DEPTH_BITS],
                          S_AXI_ARADDR[OFFS-1:0], S_AXI_ARADDR[S_AXI_ADDR_WIDTH-1:OFFS+MEM_DEPTH_BITS]};

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_RID     = r_id;
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RLAST   = r_last;
   assign S_AXI_RVALID  = r_valid;
   assign wr_burst_cnt  = wr_cnt;
   assign rd_burst_cnt  = rd_cnt;
   assign proto_err     = err;
endmodule

// File: doc/axi_ddr_responder.md
Name: axi_ddr_responder

Overview:
- AXI4 slave (responder) that terminates the AW/W/AR/R channel subset driven by the video DMA's AXI master; no B channel.
- Backed by a single-port on-chip RAM.
- Serves as a DDR stand-in for block-level simulation and as a small on-chip frame store for low-resolution test patterns.
- Same clock domain as the master's M_AXI_ACLK.

Parameters:
- S_AXI_ID_WIDTH, 4, width of all ID fields
- S_AXI_ADDR_WIDTH, 28, byte address width
- S_AXI_DATA_WIDTH, 256, data beat width; must be a power of two ≥ 32
- MEM_DEPTH_BITS, 12, RAM depth = 2^MEM_DEPTH_BITS beats
- RD_PRIORITY, 0, 1 = read wins the first simultaneous AW/AR; 0 = write wins

Ports:
- S_AXI_ACLK  in  1  the only clock
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- S_AXI_AWID  in  S_AXI_ID_WIDTH  write ID, captured with AW
- S_AXI_AWADDR  in  S_AXI_ADDR_WIDTH  write byte address
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1
- S_AXI_WID  in  S_AXI_ID_WIDTH  ignored except mismatch check
- S_AXI_WDATA  in  S_AXI_DATA_WIDTH
- S_AXI_WSTRB  in  S_AXI_DATA_WIDTH/8
- S_AXI_WLAST  in  1
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- S_AXI_ARID  in  S_AXI_ID_WIDTH
- S_AXI_ARADDR  in  S_AXI_ADDR_WIDTH
- S_AXI_ARLEN  in  8
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1
- S_AXI_RID  out  S_AXI_ID_WIDTH  equals captured ARID
- S_AXI_RDATA  out  S_AXI_DATA_WIDTH
- S_AXI_RLAST  out  1
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1
- wr_burst_cnt  out  16  completed write bursts, wraps at 0xFFFF
- rd_burst_cnt  out  16  completed read bursts, wraps at 0xFFFF
- proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, ARESETN=0):
  - All READY/VALID outputs, RLAST, RID, RDATA, both counters and proto_err go to 0.
  - FSM goes to IDLE; RAM contents undefined.
  - Reset mid-burst abandons the burst with no partial-completion count.
- Address mapping:
  - Beat index = ADDR >> log2(S_AXI_DATA_WIDTH/8), truncated to MEM_DEPTH_BITS; low bits ignored.
  - Burst address increments by one beat and wraps modulo 2^MEM_DEPTH_BITS (silent wrap, no error).
- FSM states IDLE, WBURST, RBURST:
  - IDLE: AWREADY=ARREADY=1 only while in IDLE and no handshake has occurred this cycle.
    - AW only → capture AWADDR/AWLEN, go WBURST.
    - AR only → capture, go RBURST.
    - Both valid same cycle → round-robin. First arbitration follows RD_PRIORITY; afterwards the loser of the previous contention wins. Only the winner's READY is asserted.
  - WBURST:
    - WREADY=1 continuously; each W handshake writes the RAM at the current beat index.
    - Beat counter from 0 to AWLEN. At beat AWLEN: wr_burst_cnt++, return to IDLE next cycle.
    - WLAST must be 1 exactly on beat AWLEN; otherwise set proto_err. The burst still terminates on the AWLEN count.
    - WID ≠ captured AWID sets proto_err.
  - RBURST:
    - Single-stage read pipeline. RAM read issued when (!RVALID || RREADY) and beats remain.
    - RDATA/RVALID registered one cycle after issue; 1 beat/cycle sustained with RREADY=1.
    - RDATA, RLAST and RVALID hold stable while RVALID=1 && RREADY=0.
    - RLAST=1 on beat ARLEN only.
    - Final handshake: rd_burst_cnt++, return to IDLE.
- Latency:
  - AWVALID→AWREADY: combinational in IDLE.
  - ARVALID handshake → first RVALID: 2 cycles.
  - Final WLAST handshake → AWREADY available: 1 cycle.
- Read-after-write to the same address in consecutive bursts returns the new data.
- No outstanding transactions: one burst at a time.
- AWLEN/ARLEN=0 are single-beat bursts and are legal.

Optional Feature:
- AXI_RESP_WSTRB_EN defined: RAM writes are byte-lane masked by WSTRB; lanes with strobe 0 keep prior contents.
- Undefined: WSTRB ignored; every accepted beat writes the full word.

Test Plan:
- Write 16-beat burst, AWADDR=0x000, data = beat index; then read ARADDR=0x000 ARLEN=15 with RREADY=1 → RDATA 0..15 on consecutive cycles, RLAST on 16th beat, RID=ARID, rd_burst_cnt=1, wr_burst_cnt=1.
- Simultaneous AWVALID and ARVALID with RD_PRIORITY=0, repeated twice → order write, read, write, read (round-robin); read data reflects the preceding write.
- Read 8 beats with RREADY toggling 1,0,0,1 pattern → RDATA/RLAST held during stalls, all 8 values delivered in order, no beat duplicated or dropped.
- Write burst AWLEN=3 with WLAST asserted on beat 1 → proto_err=1 and sticky; burst ends after 4 beats; next AW accepted.
- Write at beat index 2^MEM_DEPTH_BITS-2 with AWLEN=3 → beats land at depth-2, depth-1, 0, 1; readback from address 0 returns beats 3 and 4.
- With AXI_RESP_WSTRB_EN: preload all-ones, write WSTRB=0x0000_000F, data 0 → readback low 4 bytes 0, rest 0xFF; without the macro, full word reads 0.
